// File: rtl/ro_puf_core_if.sv
// ro_puf_core_if: challenge/response handshake between the PUF core and its readout logic
interface ro_puf_core_if #(
  parameter int SEL_WIDTH = 4,
  parameter int CNT_WIDTH = 16
);
  logic                 chal_valid;
  logic                 chal_ready;
  logic [SEL_WIDTH-1:0] chal_a;
  logic [SEL_WIDTH-1:0] chal_b;
  logic                 resp_valid;
  logic                 resp_ready;
  logic                 resp_bit;
  logic                 resp_tie;
  logic                 resp_sat;
  logic                 resp_err;
  logic [CNT_WIDTH-1:0] cnt_a;
  logic [CNT_WIDTH-1:0] cnt_b;
  modport master (
    output chal_valid, chal_a, chal_b, resp_ready,
    input  chal_ready, resp_valid, resp_bit, resp_tie, resp_sat, resp_err, cnt_a, cnt_b
  );
  modport slave (
    input  chal_valid, chal_a, chal_b, resp_ready,
    output chal_ready, resp_valid, resp_bit, resp_tie, resp_sat, resp_err, cnt_a, cnt_b
  );
endinterface

// File: rtl/ro_puf_core.sv
// ro_puf_core: ring-oscillator PUF measurement core comparing edge counts of two selected rings
module ro_puf_core #(
  parameter int NUM_RINGS     = 16,
  parameter int SEL_WIDTH     = $clog2(NUM_RINGS),
  parameter int CNT_WIDTH     = 16,
  parameter int SETTLE_CYCLES = 16,
  parameter int WINDOW_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [NUM_RINGS-1:0] osc_in,
  output logic [NUM_RINGS-1:0] osc_en,
  ro_puf_core_if.slave         bus
);
  localparam int PW = 1 << SEL_WIDTH;
  typedef logic [PW-1:0] pad_t;
  typedef enum logic [2:0] {IDLE, SETTLE, COUNT, COMPARE, DONE} state_t;
  state_t               state, nxt;
  logic                 rdy, ill, accept, legal, tmr_end, rise_a, rise_b;
  logic [SEL_WIDTH-1:0] sa, sb;
  logic [31:0]          tmr;
  logic [CNT_WIDTH-1:0] ca, cb;
  logic [2:0]           sya, syb;
  pad_t                 osc_pad, oh;
  // Padding to a power of two lets out-of-range indices select a harmless zero
  assign osc_pad        = pad_t'(osc_in);
  assign oh             = (pad_t'(1) << bus.chal_a) | (pad_t'(1) << bus.chal_b);
  assign bus.chal_ready = rdy & enable;
  assign bus.resp_valid = state == DONE;
  assign accept         = bus.chal_valid & bus.chal_ready;
  assign legal          = bus.chal_a != bus.chal_b && int'(bus.chal_a) < NUM_RINGS && int'(bus.chal_b) < NUM_RINGS;
  assign tmr_end        = tmr == (state == SETTLE ? SETTLE_CYCLES - 1 : WINDOW_CYCLES - 1);
  assign rise_a         = sya[1] & ~sya[2];
  assign rise_b         = syb[1] & ~syb[2];
  // Next-state logic; illegal challenges pass through COMPARE so the error response lands one cycle after accept
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = accept ? (legal ? SETTLE : COMPARE) : IDLE;
      SETTLE:  nxt = !enable ? IDLE : tmr_end ? COUNT : SETTLE;
      COUNT:   nxt = !enable ? IDLE : tmr_end ? COMPARE : COUNT;
      COMPARE: nxt = enable ? DONE : IDLE;
      DONE:    nxt = bus.resp_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  // State register; ready follows the first edge that lands in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rdy   <= 1'b0;
    end else begin
      state <= nxt;
      rdy   <= nxt == IDLE;
    end
  end
  // Phase timer, latched challenge and ring enables, which are live only in SETTLE/COUNT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr    <= '0;
      osc_en <= '0;
      sa     <= '0;
      sb     <= '0;
      ill    <= 1'b0;
    end else begin
      tmr    <= nxt == state ? tmr + 1 : '0;
      osc_en <= (nxt == SETTLE || nxt == COUNT) ? (accept ? oh[NUM_RINGS-1:0] : osc_en) : '0;
      if (accept) begin
        sa  <= bus.chal_a;
        sb  <= bus.chal_b;
        ill <= !legal;
      end
    end
  end
  // Two-flop synchronisers plus an edge-history flop for the selected rings
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sya <= '0;
      syb <= '0;
    end else begin
      sya <= {sya[1:0], osc_pad[sa]};
      syb <= {syb[1:0], osc_pad[sb]};
    end
  end
  // Saturating edge counters, cleared while the rings settle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ca <= '0;
      cb <= '0;
    end else if (state == SETTLE) begin
      ca <= '0;
      cb <= '0;
    end else if (state == COUNT) begin
      if (rise_a && !(&ca)) ca <= ca + 1'b1;
      if (rise_b && !(&cb)) cb <= cb + 1'b1;
    end
  end
  // Response registers, written once per challenge and held through DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.resp_bit <= 1'b0;
      bus.resp_tie <= 1'b0;
      bus.resp_sat <= 1'b0;
      bus.resp_err <= 1'b0;
      bus.cnt_a    <= '0;
      bus.cnt_b    <= '0;
    end else if (state == COMPARE && enable) begin
      bus.resp_bit <= !ill && ca > cb;
      bus.resp_tie <= !ill && ca == cb;
      bus.resp_sat <= !ill && ((&ca) || (&cb));
      bus.resp_err <= ill;
      if (!ill) begin
        bus.cnt_a <= ca;
        bus.cnt_b <= cb;
      end
    end
  end
endmodule

// File: tb/tb_ro_puf_core.sv
// tb_ro_puf_core: directed self-checking bench for the ring-oscillator PUF core
module tb_ro_puf_core;
  logic        clk = 0, rst_n = 0, enable = 1;
  logic [15:0] osc = '0, en1, en2;
  int          per[16] = '{default: 0};
  int          cyc = 0;
  int          cmp = 0, bad = 0;
  ro_puf_core_if #(.SEL_WIDTH(5), .CNT_WIDTH(16)) bi();
  ro_puf_core_if #(.SEL_WIDTH(4), .CNT_WIDTH(8))  bs();
  ro_puf_core #(.NUM_RINGS(16), .SEL_WIDTH(5)) u1 (.clk(clk), .rst_n(rst_n), .enable(enable), .osc_in(osc), .osc_en(en1), .bus(bi));
  ro_puf_core #(.NUM_RINGS(16), .CNT_WIDTH(8)) u2 (.clk(clk), .rst_n(rst_n), .enable(enable), .osc_in(osc), .osc_en(en2), .bus(bs));
  always #5 clk = ~clk;
  // Ring models: square waves of per[i] clock periods, all phase-aligned to one cycle counter
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 16; i++) osc[i] = per[i] != 0 && (cyc % per[i]) < per[i] / 2;
  end
  task automatic run1(input logic [4:0] a, input logic [4:0] b, output int lat, output logic [15:0] mid, output logic [15:0] seen);
    int w = 0;
    lat = 0; mid = '0; seen = '0;
    while (!bi.chal_ready && w < 20) begin @(posedge clk); #1; w++; end
    cmp++; if (bi.chal_ready !== 1'b1) begin bad++; $display("FAIL ready_wait: got %b want 1", bi.chal_ready); end
    bi.chal_a = a; bi.chal_b = b; bi.chal_valid = 1;
    @(posedge clk); #1;
    bi.chal_valid = 0;
    while (bi.resp_valid !== 1'b1 && lat < 3000) begin
      seen |= en1;
      if (lat == 500) mid = en1;
      @(posedge clk); #1; lat++;
    end
  endtask
  task automatic consume1();
    bi.resp_ready = 1;
    @(posedge clk); #1;
    bi.resp_ready = 0;
  endtask
  task automatic test_reset();
    #12;
    cmp++; if (bi.resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid: got %b want 0", bi.resp_valid); end
    cmp++; if (en1 !== 16'h0) begin bad++; $display("FAIL rst_osc_en: got %h want 0000", en1); end
    cmp++; if ({bi.resp_bit, bi.resp_tie, bi.resp_sat, bi.resp_err} !== 4'b0) begin bad++; $display("FAIL rst_flags: got %b want 0000", {bi.resp_bit, bi.resp_tie, bi.resp_sat, bi.resp_err}); end
    cmp++; if ({bi.cnt_a, bi.cnt_b} !== 32'h0) begin bad++; $display("FAIL rst_cnt: got %h want 0", {bi.cnt_a, bi.cnt_b}); end
    rst_n = 1; #1;
    cmp++; if (bi.chal_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_before_edge: got %b want 0", bi.chal_ready); end
    @(posedge clk); #1;
    cmp++; if (bi.chal_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after_edge: got %b want 1", bi.chal_ready); end
  endtask
  task automatic test_measure();
    int lat; logic [15:0] mid, seen;
    per[3] = 8; per[5] = 10;
    run1(5'd3, 5'd5, lat, mid, seen);
    cmp++; if (lat != 1041) begin bad++; $display("FAIL meas_latency: got %0d want 1041", lat); end
    cmp++; if (mid !== 16'h0028) begin bad++; $display("FAIL meas_osc_en: got %h want 0028", mid); end
    cmp++; if (bi.cnt_a < 127 || bi.cnt_a > 129) begin bad++; $display("FAIL meas_cnt_a: got %0d want 127..129", bi.cnt_a); end
    cmp++; if (bi.cnt_b < 101 || bi.cnt_b > 103) begin bad++; $display("FAIL meas_cnt_b: got %0d want 101..103", bi.cnt_b); end
    cmp++; if ({bi.resp_bit, bi.resp_tie, bi.resp_sat, bi.resp_err} !== 4'b1000) begin bad++; $display("FAIL meas_flags: got %b want 1000", {bi.resp_bit, bi.resp_tie, bi.resp_sat, bi.resp_err}); end
    cmp++; if (en1 !== 16'h0) begin bad++; $display("FAIL meas_osc_en_done: got %h want 0000", en1); end
    consume1();
  endtask
  task automatic test_swap();
    int lat; logic [15:0] mid, seen;
    run1(5'd5, 5'd3, lat, mid, seen);
    cmp++; if ({bi.resp_bit, bi.resp_tie, bi.resp_err} !== 3'b000) begin bad++; $display("FAIL swap_flags: got %b want 000", {bi.resp_bit, bi.resp_tie, bi.resp_err}); end
    cmp++; if (bi.cnt_a < 101 || bi.cnt_a > 103) begin bad++; $display("FAIL swap_cnt_a: got %0d want 101..103", bi.cnt_a); end
    consume1();
  endtask
  task automatic test_tie();
    int lat; logic [15:0] mid, seen;
    per[5] = 8;
    run1(5'd3, 5'd5, lat, mid, seen);
    cmp++; if ({bi.resp_bit, bi.resp_tie} !== 2'b01) begin bad++; $display("FAIL tie_flags: got %b want 01", {bi.resp_bit, bi.resp_tie}); end
    cmp++; if (bi.cnt_a < 127 || bi.cnt_a > 129) begin bad++; $display("FAIL tie_cnt_a: got %0d want 127..129", bi.cnt_a); end
    consume1();
    per[5] = 10;
  endtask
  task automatic test_illegal();
    int lat; logic [15:0] mid, seen, prev;
    prev = bi.cnt_a;
    run1(5'd7, 5'd7, lat, mid, seen);
    cmp++; if (lat != 1) begin bad++; $display("FAIL ill77_latency: got %0d want 1", lat); end
    cmp++; if ({bi.resp_bit, bi.resp_tie, bi.resp_sat, bi.resp_err} !== 4'b0001) begin bad++; $display("FAIL ill77_flags: got %b want 0001", {bi.resp_bit, bi.resp_tie, bi.resp_sat, bi.resp_err}); end
    cmp++; if ((seen | en1) !== 16'h0) begin bad++; $display("FAIL ill77_osc_en: got %h want 0000", seen | en1); end
    cmp++; if (bi.cnt_a !== prev) begin bad++; $display("FAIL ill77_cnt_hold: got %0d want %0d", bi.cnt_a, prev); end
    consume1();
    run1(5'd16, 5'd2, lat, mid, seen);
    cmp++; if (lat != 1) begin bad++; $display("FAIL ill162_latency: got %0d want 1", lat); end
    cmp++; if (bi.resp_err !== 1'b1) begin bad++; $display("FAIL ill162_err: got %b want 1", bi.resp_err); end
    cmp++; if ((seen | en1) !== 16'h0) begin bad++; $display("FAIL ill162_osc_en: got %h want 0000", seen | en1); end
    consume1();
  endtask
  task automatic test_sat();
    int w = 0, lat = 0;
    per[0] = 4; per[1] = 16;
    while (!bs.chal_ready && w < 20) begin @(posedge clk); #1; w++; end
    bs.chal_a = 4'd0; bs.chal_b = 4'd1; bs.chal_valid = 1;
    @(posedge clk); #1;
    bs.chal_valid = 0;
    while (bs.resp_valid !== 1'b1 && lat < 3000) begin @(posedge clk); #1; lat++; end
    cmp++; if (lat != 1041) begin bad++; $display("FAIL sat_latency: got %0d want 1041", lat); end
    cmp++; if (bs.cnt_a !== 8'd255) begin bad++; $display("FAIL sat_cnt_a: got %0d want 255", bs.cnt_a); end
    cmp++; if (bs.cnt_b < 63 || bs.cnt_b > 65) begin bad++; $display("FAIL sat_cnt_b: got %0d want 63..65", bs.cnt_b); end
    cmp++; if ({bs.resp_bit, bs.resp_tie, bs.resp_sat} !== 3'b101) begin bad++; $display("FAIL sat_flags: got %b want 101", {bs.resp_bit, bs.resp_tie, bs.resp_sat}); end
    bs.resp_ready = 1;
    @(posedge clk); #1;
    bs.resp_ready = 0;
  endtask
  task automatic test_abort();
    int w = 0, hits = 0;
    while (!bi.chal_ready && w < 20) begin @(posedge clk); #1; w++; end
    bi.chal_a = 5'd3; bi.chal_b = 5'd5; bi.chal_valid = 1;
    @(posedge clk); #1;
    bi.chal_valid = 0;
    repeat (516) begin @(posedge clk); #1; end
    cmp++; if (en1 !== 16'h0028) begin bad++; $display("FAIL abort_osc_en_running: got %h want 0028", en1); end
    enable = 0;
    @(posedge clk); #1;
    cmp++; if (en1 !== 16'h0) begin bad++; $display("FAIL abort_osc_en: got %h want 0000", en1); end
    enable = 1;
    repeat (1100) begin @(posedge clk); #1; if (bi.resp_valid === 1'b1 || en1 !== 16'h0) hits++; end
    cmp++; if (hits != 0) begin bad++; $display("FAIL abort_no_resp: got %0d busy cycles want 0", hits); end
    cmp++; if (bi.chal_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", bi.chal_ready); end
  endtask
  task automatic test_back_to_back();
    int lat, n = 0; logic [15:0] mid, seen; logic [32:0] snap;
    run1(5'd3, 5'd5, lat, mid, seen);
    snap = {bi.resp_bit, bi.cnt_a, bi.cnt_b};
    repeat (20) begin
      @(posedge clk); #1;
      if (bi.resp_valid !== 1'b1 || bi.chal_ready !== 1'b0 || {bi.resp_bit, bi.cnt_a, bi.cnt_b} !== snap) n++;
    end
    cmp++; if (n != 0) begin bad++; $display("FAIL hold_stable: got %0d unstable cycles want 0", n); end
    cmp++; if (snap[32] !== 1'b1) begin bad++; $display("FAIL hold_bit: got %b want 1", snap[32]); end
    consume1();
    cmp++; if ({bi.resp_valid, bi.chal_ready} !== 2'b01) begin bad++; $display("FAIL b2b_handshake: got %b want 01", {bi.resp_valid, bi.chal_ready}); end
  endtask
  task automatic test_reset_mid();
    int w = 0, lat; logic [15:0] mid, seen;
    while (!bi.chal_ready && w < 20) begin @(posedge clk); #1; w++; end
    bi.chal_a = 5'd3; bi.chal_b = 5'd5; bi.chal_valid = 1;
    @(posedge clk); #1;
    bi.chal_valid = 0;
    repeat (300) begin @(posedge clk); #1; end
    #2 rst_n = 0;
    #1;
    cmp++; if (en1 !== 16'h0) begin bad++; $display("FAIL arst_osc_en: got %h want 0000", en1); end
    cmp++; if ({bi.chal_ready, bi.resp_valid, bi.resp_bit} !== 3'b000) begin bad++; $display("FAIL arst_ctrl: got %b want 000", {bi.chal_ready, bi.resp_valid, bi.resp_bit}); end
    cmp++; if ({bi.cnt_a, bi.cnt_b} !== 32'h0) begin bad++; $display("FAIL arst_cnt: got %h want 0", {bi.cnt_a, bi.cnt_b}); end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    run1(5'd3, 5'd5, lat, mid, seen);
    cmp++; if (lat != 1041) begin bad++; $display("FAIL arst_latency: got %0d want 1041", lat); end
    cmp++; if (bi.resp_bit !== 1'b1 || bi.cnt_a < 127 || bi.cnt_a > 129) begin bad++; $display("FAIL arst_remeasure: got bit %b cnt_a %0d want bit 1 cnt_a 127..129", bi.resp_bit, bi.cnt_a); end
    consume1();
  endtask
  initial begin
    bi.chal_valid = 0; bi.chal_a = '0; bi.chal_b = '0; bi.resp_ready = 0;
    bs.chal_valid = 0; bs.chal_a = '0; bs.chal_b = '0; bs.resp_ready = 0;
    test_reset();
    test_measure();
    test_swap();
    test_tie();
    test_illegal();
    test_sat();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule

// File: doc/ro_puf_core.md
# ro_puf_core

Parametrised ring-oscillator PUF measurement core. It selects two of NUM_RINGS externally instantiated ring oscillators per challenge and enables only those two. It counts their rising edges over a fixed window in the system clock domain, then returns one response bit (ring A faster than ring B) with tie, saturation and error flags. It sits between the ring-oscillator array, which is instantiated alongside it at top level, and the key-generation/readout logic.

## Interface
- NUM_RINGS, 16: number of ring oscillators in the array (2..256)
- SEL_WIDTH, $clog2(NUM_RINGS): width of challenge indices
- CNT_WIDTH, 16: edge-counter width (4..32)
- SETTLE_CYCLES, 16: cycles rings run before counting starts (>=1)
- WINDOW_CYCLES, 1024: counting window length in Clk cycles (>=1)
- Clk  input  1  system clock; single clock domain
- Rst_n  input  1  asynchronous, active-low reset
- Enable  input  1  block enable; low aborts any measurement
- Chal_valid  input  1  challenge offered
- Chal_ready  output  1  challenge accepted when high with Chal_valid
- Chal_a  input  SEL_WIDTH  index of ring A
- Chal_b  input  SEL_WIDTH  index of ring B
- Osc_in  input  NUM_RINGS  raw ring outputs (asynchronous to Clk)
- Osc_en  output  NUM_RINGS  per-ring enable to the array
- Resp_valid  output  1  response available
- Resp_ready  input  1  response consumed when high with Resp_valid
- Resp_bit  output  1  1 when count A > count B
- Resp_tie  output  1  counts equal
- Resp_sat  output  1  either counter saturated
- Resp_err  output  1  illegal challenge, no measurement taken
- Cnt_a, Cnt_b  output  CNT_WIDTH each  final edge counts (debug)

## Operation
- FSM states: IDLE, SETTLE, COUNT, COMPARE, DONE.
- IDLE: Chal_ready = Enable. On Chal_valid && Chal_ready, latch Chal_a and Chal_b.
  - Illegal challenge: Chal_a == Chal_b, or either index >= NUM_RINGS. Go to DONE with Resp_err=1 and Resp_bit/tie/sat=0; Cnt_a/Cnt_b hold their previous values.
  - Legal challenge: go to SETTLE.
- SETTLE: Osc_en has exactly bits a and b set. Both counters are cleared. The phase lasts SETTLE_CYCLES cycles, then the FSM moves to COUNT.
- COUNT: lasts WINDOW_CYCLES cycles.
  - Osc_in[a] and Osc_in[b] each pass through a 2-flop synchroniser and then a rising-edge detector (s2 & ~s3).
  - Each detected edge increments the corresponding counter.
  - Counters saturate at 2^CNT_WIDTH-1 and set a sticky saturation flag.
  - Synchronisers run in every state; only edges detected during COUNT cycles are counted.
- COMPARE: one cycle. Osc_en is cleared. Register Resp_bit = (cnt_a > cnt_b), Resp_tie = (cnt_a == cnt_b), Resp_sat = sat_a | sat_b, and Cnt_a/Cnt_b.
- DONE: Resp_valid=1. Response outputs are held stable until Resp_valid && Resp_ready, then the FSM returns to IDLE.
- Enable low in SETTLE, COUNT or COMPARE: on the next edge go to IDLE, clear Osc_en, produce no response.
- Enable low in DONE: the response stays pending until consumed.
- Measurement constraint: valid only if every ring frequency is below Clk/4. Faster rings under-count; this is not detected.
- Counts are unsigned; the comparison is unsigned, CNT_WIDTH bits.

## Timing
- Reset values:
  - State = IDLE.
  - Chal_ready = 0 until the first edge after reset release with Enable=1.
  - Osc_en = 0, Resp_valid = 0, Resp_bit/tie/sat/err = 0, Cnt_a = Cnt_b = 0.
  - Synchroniser flops = 0.
- Latency, legal challenge: accepted at edge k. Osc_en is set from edge k. Resp_valid rises at edge k+SETTLE_CYCLES+WINDOW_CYCLES+1.
- Latency, illegal challenge: accepted at edge k, Resp_valid rises at edge k+1.
- Back-to-back: Resp_ready high while Resp_valid is high returns the FSM to IDLE on that edge. Chal_ready is high the following cycle, so there is a minimum one-cycle gap between responses.
- Osc_en is never nonzero outside SETTLE/COUNT.
- Synchroniser delay means edges occurring in the final 2 cycles of the window are not counted. This offset is identical for both rings.

## Test plan
- Measurement, A faster: SETTLE=16, WINDOW=1024. Osc_in[3] has period 8 Clk, Osc_in[5] has period 10; challenge (3,5) -> Cnt_a=128±1, Cnt_b=102±1, Resp_bit=1, tie=0, Osc_en=16'h0028 during measurement, Resp_valid exactly 1041 cycles after accept.
- Swapped and tie: challenge (5,3) -> Resp_bit=0. Both rings with period 8 and aligned phase -> Resp_tie=1, Resp_bit=0.
- Illegal challenges: (7,7) and (16,2) with NUM_RINGS=16 -> Resp_err=1 one cycle after accept, Osc_en never nonzero.
- Saturation: CNT_WIDTH=8, ring period 4 versus period 16 -> Cnt_a=255, Resp_sat=1, Resp_bit=1.
- Abort and handshake:
  - Enable dropped at cycle 500 of COUNT -> IDLE next edge, Osc_en=0, no Resp_valid.
  - Resp_ready held low 20 cycles -> response stable, Chal_ready=0 throughout.
- Async reset mid-COUNT: Rst_n pulsed low asynchronously -> all outputs at reset values immediately. After release, a new challenge measures normally.
